// File: rtl/mem_stage_ctrl_pkg.sv
// Shared definitions for the MEM-stage access controller: FSM state encoding
// and default datapath widths.
package mem_stage_ctrl_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } mem_state_e;

endpackage

// File: rtl/mem_stage_ctrl.sv
// MEM-stage access controller: issues loads/stores over a valid/ready request,
// waits for the response and stalls the pipeline meanwhile.
// Optional feature: define MEMCTL_POSTED_WRITE_EN to post stores (no wait on the ack).
module mem_stage_ctrl
  import mem_stage_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              MEM_MemRead,
  input  logic              MEM_MemWrite,
  input  logic              MEM_MemtoReg,
  input  logic              MEM_RegWrite,
  input  logic              MEM_Halt,
  input  logic              MEM_PCSave,
  input  logic [3:0]        MEM_rd,
  input  logic [DATA_W-1:0] MEM_AluResult,
  input  logic [DATA_W-1:0] MEM_ReadData2,
  input  logic [DATA_W-1:0] MEM_pc,
  output logic              dm_req_valid,
  input  logic              dm_req_ready,
  output logic              dm_req_we,
  output logic [ADDR_W-1:0] dm_req_addr,
  output logic [DATA_W-1:0] dm_req_wdata,
  input  logic              dm_rsp_valid,
  input  logic [DATA_W-1:0] dm_rsp_data,
  output logic              mem_stall,
  output logic [DATA_W-1:0] WB_result,
  output logic [3:0]        WB_rd,
  output logic              WB_RegWrite,
  output logic              WB_Halt,
  output logic              dm_err
);

  mem_state_e        state_r;
  mem_state_e        next_state_s;
  logic [DATA_W-1:0] rdata_q;
  logic              dm_err_r;
  logic              mem_op_s;
  logic              pend_s;
  logic              req_valid_s;
  logic              stall_s;
  logic              handshake_s;
  logic              stray_rsp_s;

  assign mem_op_s    = MEM_MemRead | MEM_MemWrite;
  assign handshake_s = req_valid_s & dm_req_ready;
  // A response outside WAIT is only legal as the ack of a posted store.
  assign stray_rsp_s = dm_rsp_valid & (((state_r == IDLE) & ~pend_s) | (state_r == DONE));

`ifdef MEMCTL_POSTED_WRITE_EN
  logic pend_q;
  assign pend_s = pend_q;

  // Posted-store tracker: set on store acceptance, cleared by the write ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= 1'b0;
    end else if (handshake_s && MEM_MemWrite) begin
      pend_q <= 1'b1;
    end else if (pend_q && dm_rsp_valid) begin
      pend_q <= 1'b0;
    end else begin
      pend_q <= pend_q;
    end
  end
`else
  assign pend_s = 1'b0;
`endif

  // Next-state and request/stall decode.
  always_comb begin
    next_state_s = state_r;
    req_valid_s  = 1'b0;
    stall_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (mem_op_s && pend_s) begin
          stall_s = 1'b1;
        end else if (mem_op_s) begin
          req_valid_s = 1'b1;
`ifdef MEMCTL_POSTED_WRITE_EN
          if (MEM_MemWrite) begin
            stall_s = ~dm_req_ready;
          end else begin
            stall_s = 1'b1;
            if (dm_req_ready) begin
              next_state_s = WAIT;
            end else begin
              next_state_s = IDLE;
            end
          end
`else
          stall_s = 1'b1;
          if (dm_req_ready) begin
            next_state_s = WAIT;
          end else begin
            next_state_s = IDLE;
          end
`endif
        end else begin
          stall_s = 1'b0;
        end
      end
      WAIT: begin
        stall_s = 1'b1;
        if (dm_rsp_valid) begin
          next_state_s = DONE;
        end else begin
          next_state_s = WAIT;
        end
      end
      DONE: begin
        next_state_s = IDLE;
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // State, captured load data and sticky protocol error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      rdata_q  <= {DATA_W{1'b0}};
      dm_err_r <= 1'b0;
    end else begin
      state_r <= next_state_s;
      if (state_r == WAIT && dm_rsp_valid) begin
        rdata_q <= dm_rsp_data;
      end else begin
        rdata_q <= rdata_q;
      end
      dm_err_r <= dm_err_r | stray_rsp_s;
    end
  end

  // Writeback value select; load data only exists in DONE.
  always_comb begin
    WB_result = MEM_AluResult;
    if (state_r == DONE && MEM_MemtoReg) begin
      WB_result = rdata_q;
    end else if (MEM_PCSave) begin
      WB_result = MEM_pc;
    end else begin
      WB_result = MEM_AluResult;
    end
  end

  assign dm_req_valid = req_valid_s;
  assign dm_req_we    = req_valid_s & MEM_MemWrite;
  assign dm_req_addr  = MEM_AluResult[ADDR_W-1:0];
  assign dm_req_wdata = MEM_ReadData2;
  assign mem_stall    = stall_s;
  assign WB_rd        = MEM_rd;
  assign WB_RegWrite  = MEM_RegWrite & ~stall_s;
  assign WB_Halt      = MEM_Halt & ~stall_s;
  assign dm_err       = dm_err_r;

endmodule

// File: doc/mem_stage_ctrl.md
# mem_stage_ctrl

Memory-stage access controller sitting directly downstream of the EX/MEM pipeline register. It consumes the registered MEM-stage control and datapath signals, runs load and store accesses against a variable-latency data memory over a valid/ready request and valid response handshake, and drives the stall that freezes the upstream pipeline registers while an access is outstanding. It presents the stage result (load data, ALU result or saved PC) to the MEM/WB register.

## Interface
- ADDR_W, 16, data-memory address width
- DATA_W, 16, data word width
- clk  input  1  pipeline clock, all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- MEM_MemRead  input  1  load in MEM stage
- MEM_MemWrite  input  1  store in MEM stage
- MEM_MemtoReg  input  1  writeback selects load data
- MEM_RegWrite  input  1  instruction writes rd
- MEM_Halt  input  1  halt marker
- MEM_PCSave  input  1  writeback selects MEM_pc
- MEM_rd  input  4  destination register
- MEM_AluResult  input  DATA_W  address / ALU result
- MEM_ReadData2  input  DATA_W  store data
- MEM_pc  input  DATA_W  PC value to save
- dm_req_valid  output  1  memory request valid
- dm_req_ready  input  1  memory accepts request
- dm_req_we  output  1  1 = write, 0 = read
- dm_req_addr  output  ADDR_W  = MEM_AluResult[ADDR_W-1:0]
- dm_req_wdata  output  DATA_W  = MEM_ReadData2
- dm_rsp_valid  input  1  read data / write ack, one per accepted request
- dm_rsp_data  input  DATA_W  read data, ignored for writes
- mem_stall  output  1  freeze PC, IF/ID, ID/EX, EX/MEM, and bubble MEM/WB
- WB_result  output  DATA_W  writeback value
- WB_rd  output  4  pass-through of MEM_rd
- WB_RegWrite  output  1  MEM_RegWrite & ~mem_stall
- WB_Halt  output  1  MEM_Halt & ~mem_stall
- dm_err  output  1  sticky: dm_rsp_valid seen with no access outstanding

## Operation
- FSM states: IDLE, WAIT, DONE. Reset → IDLE.
- mem_op = MEM_MemRead | MEM_MemWrite. If both are set, treat the access as a write.
- IDLE, no mem_op: dm_req_valid = 0, mem_stall = 0. WB_result = MEM_pc if MEM_PCSave, else MEM_AluResult.
- IDLE, mem_op: dm_req_valid = 1 and mem_stall = 1. dm_req_valid stays asserted with stable addr/we/wdata until dm_req_ready.
  - Handshake (valid & ready) → WAIT.
- WAIT: dm_req_valid = 0, mem_stall = 1.
  - On dm_rsp_valid: capture dm_rsp_data into rdata_q, go to DONE.
- DONE: mem_stall = 0, dm_req_valid = 0.
  - WB_result = rdata_q if MEM_MemtoReg, else the non-load selection.
  - Next state IDLE. The EX/MEM register advances at this edge, so the same access is never reissued.
- Results: WB_rd is always a pass-through. Downstream ignores WB_result when WB_RegWrite = 0.
- dm_err: set on dm_rsp_valid in IDLE or DONE with no posted write pending. Cleared only by reset.
- Reset mid-access: the FSM returns to IDLE, the outstanding request is abandoned, and rdata_q and dm_err are cleared. Memory-side cleanup is outside this block.
- Reset values: dm_req_valid 0, dm_req_we 0, mem_stall 0, WB_RegWrite 0, WB_Halt 0, dm_err 0, rdata_q 0. Pass-through outputs follow their inputs.

## Timing
- Load or store accepted in cycle 0, response in cycle k ≥ 1:
  - mem_stall is high in cycles 0..k.
  - DONE occurs in cycle k+1 with mem_stall low.
  - Total stall is k+1 cycles; best case (ready immediately, k = 1) is 2 stall cycles.
- Each cycle dm_req_ready is low before acceptance adds one stall cycle.
- Non-memory instructions: zero added latency, fully combinational path to WB outputs.
- dm_rsp_valid arriving in the same cycle as acceptance is illegal. A response only counts from WAIT.

## Configuration
- MEMCTL_POSTED_WRITE_EN
- Defined: stores are posted.
  - A store leaves IDLE→IDLE on handshake, and mem_stall goes low in the acceptance cycle.
  - The pend_q bit is set and cleared by the write ack (dm_rsp_valid).
  - While pend_q = 1, any new mem_op holds mem_stall = 1 with dm_req_valid = 0. It issues no earlier than the cycle after the ack.
  - A load response is never confused with a write ack.
- Undefined: stores use the full IDLE→WAIT→DONE path like loads, pend_q is absent, and mem_stall is as above.

## Structure
- Shared package: FSM state enum (IDLE, WAIT, DONE) and the ADDR_W/DATA_W defaults.
- A single module with no sub-modules. rdata_q and pend_q are local registers; the reset style is async active-low throughout.

## Test plan
- ALU op, MEM_AluResult = 0x1234, RegWrite = 1 → WB_result = 0x1234, mem_stall never high.
- PCSave with MEM_pc = 0x0042 → WB_result = 0x0042.
- Load addr 0x0010, ready immediate, rsp 0xBEEF three cycles later:
  - mem_stall high exactly 4 cycles.
  - DONE cycle shows WB_result = 0xBEEF and WB_RegWrite = 1.
- Load with dm_req_ready low for 2 cycles: addr and we stay stable, and there is exactly one handshake.
- Store 0x00AA to 0x0020:
  - Undefined macro: stall until ack, dm_req_we = 1, wdata = 0x00AA.
  - Defined macro: stall low in the accept cycle; a following load stalls until the ack, then issues.
- rst_n pulsed low while in WAIT → FSM back in IDLE, mem_stall 0; a stray dm_rsp_valid afterwards sets dm_err = 1.
